// File: rtl/turnstile_pkg.sv
// -----------------------------------------------------------------------------
// turnstile_pkg
// Shared definitions for the turnstile card-code interface: the transmit FSM
// state encoding, code/frame widths, and the legal code window that the
// turnstile controller enforces.
//
// Build option: CARD_CODE_PARITY_EN
//   defined   -> 5-bit frame (4 code bits + even parity bit)
//   undefined -> 4-bit frame (code bits only)
// -----------------------------------------------------------------------------
package turnstile_pkg;

    // Encodings are fixed; they are visible on state_out. Value 7 is unused
    // and treated as illegal by the FSM.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_CHECK      = 3'd2,
        ST_SEND       = 3'd3,
        ST_WAIT_RESP  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_REMOVE     = 3'd6
    } state_e;

    localparam int CODE_W = 4;

`ifdef CARD_CODE_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    // Bit counter width, wide enough to index every frame bit.
    localparam int CNT_W = 3;

    // Legal access-code window. Enforced by the controller, not by this block.
    localparam logic [CODE_W-1:0] CODE_MIN = 4'd4;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'd11;

    // Even parity: the XOR over the whole frame must be zero.
    function automatic logic frame_parity_ok(input logic [FRAME_LEN-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/card_frame_shift.sv
// -----------------------------------------------------------------------------
// card_frame_shift
// Serial-to-parallel capture of one card frame, MSB first.
//
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : synchronous, active-low
//   clear      in  : synchronous clear of shift register and bit counter
//   shift_en   in  : capture card_bit this cycle
//   card_bit   in  : serial data
//   frame_done out : high in the cycle the last frame bit is captured
//   frame_data out : captured frame, first received bit in the MSB
//
// Frame length follows FRAME_LEN (selected by CARD_CODE_PARITY_EN).
// -----------------------------------------------------------------------------
module card_frame_shift
    import turnstile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 card_bit,
    output logic                 frame_done,
    output logic [FRAME_LEN-1:0] frame_data
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] bit_cnt;

    // Done is asserted alongside the strobe that carries the last bit, so
    // the FSM leaves SHIFT on the same edge that captures it.
    assign frame_done = shift_en && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            bit_cnt    <= '0;
            frame_data <= '0;
        end else if (shift_en) begin
            frame_data <= {frame_data[FRAME_LEN-2:0], card_bit};
            bit_cnt    <= frame_done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/card_code_tx.sv
// -----------------------------------------------------------------------------
// card_code_tx
// Transmitting end of the turnstile code interface. Collects a serial card
// frame, optionally checks even parity, strobes the 4-bit code to the
// turnstile controller and classifies the controller's door response as
// granted or denied. One transaction per card tap.
//
// Parameters:
//   RESP_TIMEOUT : cycles from valid_code to denial if the door never opens
//                  (legal 3..15)
//
// Ports:
//   clk              in  : clock, rising edge
//   reset            in  : synchronous, active-low
//   card_present     in  : card in the reader field
//   card_bit         in  : serial frame data, MSB first
//   card_bit_valid   in  : card_bit strobe
//   open_access_door in  : door-open response from the controller
//   valid_code       out : one-cycle code strobe (SEND state)
//   access_code      out : code to the controller, held SEND..IDLE
//   granted          out : one-cycle pulse, door opened and closed
//   denied           out : one-cycle pulse, response timeout
//   parity_err       out : one-cycle pulse, bad frame parity
//   busy             out : state is not IDLE
//   state_out        out : current state encoding
//
// Build option: CARD_CODE_PARITY_EN enables the parity bit and check; when
// undefined the frame is 4 bits and parity_err is constant 0.
//
// Handshake: valid_code is a pure strobe with no ready; the controller must
// sample access_code in the valid_code cycle, and answers by raising
// open_access_door (no earlier than 2 cycles later) and dropping it when the
// door closes.
// -----------------------------------------------------------------------------
module card_code_tx
    import turnstile_pkg::*;
#(
    parameter int RESP_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              card_present,
    input  logic              card_bit,
    input  logic              card_bit_valid,
    input  logic              open_access_door,
    output logic              valid_code,
    output logic [CODE_W-1:0] access_code,
    output logic              granted,
    output logic              denied,
    output logic              parity_err,
    output logic              busy,
    output logic [2:0]        state_out
);

    localparam logic [3:0] RESP_LAST = 4'(RESP_TIMEOUT - 1);

    state_e                state;
    state_e                state_nx;
    logic [3:0]            resp_cnt;
    logic                  abort;
    logic                  shift_en;
    logic                  frame_clear;
    logic                  frame_done;
    logic [FRAME_LEN-1:0]  frame_data;
    logic [CODE_W-1:0]     frame_code;
    logic                  parity_ok;
    logic                  granted_nx;
    logic                  denied_nx;

    // Card removal only aborts while the frame is still arriving.
    assign abort       = (state == ST_SHIFT) && !card_present;
    assign shift_en    = (state == ST_SHIFT) && card_present && card_bit_valid;
    assign frame_clear = (state == ST_IDLE) || abort;

    // Code bits are the first CODE_W bits received; parity (if any) is last.
    assign frame_code = frame_data[FRAME_LEN-1 -: CODE_W];

`ifdef CARD_CODE_PARITY_EN
    assign parity_ok = frame_parity_ok(frame_data);
`else
    assign parity_ok = 1'b1;
`endif

    card_frame_shift u_shift (
        .clk        (clk),
        .reset      (reset),
        .clear      (frame_clear),
        .shift_en   (shift_en),
        .card_bit   (card_bit),
        .frame_done (frame_done),
        .frame_data (frame_data)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (card_present) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!card_present)   state_nx = ST_IDLE;
                else if (frame_done) state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                state_nx = parity_ok ? ST_SEND : ST_REMOVE;
            end
            ST_SEND: begin
                state_nx = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // A door opening in the final counted cycle still wins.
                if (open_access_door)           state_nx = ST_WAIT_CLOSE;
                else if (resp_cnt == RESP_LAST) state_nx = ST_REMOVE;
            end
            ST_WAIT_CLOSE: begin
                if (!open_access_door) state_nx = ST_REMOVE;
            end
            ST_REMOVE: begin
                if (!card_present) state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        valid_code = (state == ST_SEND);
        busy       = (state != ST_IDLE);
        state_out  = state;
        granted_nx = (state == ST_WAIT_CLOSE) && !open_access_door;
        denied_nx  = (state == ST_WAIT_RESP) && !open_access_door &&
                     (resp_cnt == RESP_LAST);
    end

    // --------------------------------------------------------------- datapath
    // resp_cnt counts cycles since valid_code: 0 in SEND, so the last
    // WAIT_RESP cycle is SEND+RESP_TIMEOUT-1 and denied lands on
    // SEND+RESP_TIMEOUT. It saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_cnt    <= '0;
            access_code <= '0;
            granted     <= 1'b0;
            denied      <= 1'b0;
        end else begin
            granted <= granted_nx;
            denied  <= denied_nx;

            if (state == ST_SEND || state == ST_WAIT_RESP) begin
                if (resp_cnt != RESP_LAST) resp_cnt <= resp_cnt + 4'd1;
            end else begin
                resp_cnt <= '0;
            end

            if (state_nx == ST_IDLE) begin
                access_code <= '0;
            end else if (state == ST_CHECK && state_nx == ST_SEND) begin
                access_code <= frame_code;
            end
        end
    end

`ifdef CARD_CODE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (state == ST_CHECK) && !parity_ok;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_card_code_tx.sv
// -----------------------------------------------------------------------------
// tb_card_code_tx
// Directed bench for card_code_tx. Inputs change on the falling edge and
// outputs are checked on the falling edge, i.e. half a cycle after the
// rising edge that produced them. A table of card transactions is replayed
// against a scripted controller, followed by hand-written sequences for
// abort, reset mid-transaction and a card held after grant.
// Builds with or without CARD_CODE_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_card_code_tx;
    import turnstile_pkg::*;

    localparam int T = 4;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_GR   = 3'b100;   // {granted, denied, parity_err}
    localparam logic [2:0] R_DN   = 3'b010;
    localparam logic [2:0] R_PE   = 3'b001;
`ifdef CARD_CODE_PARITY_EN
    localparam logic [2:0] R_BAD  = R_PE;
    localparam int         NBITS  = 5;
`else
    localparam logic [2:0] R_BAD  = R_DN;     // no parity check: plain timeout
    localparam int         NBITS  = 4;
`endif

    // ------------------------------------------------------ clock / reset
    logic       clk = 1'b0;
    logic       reset;
    logic       card_present;
    logic       card_bit;
    logic       card_bit_valid;
    logic       open_access_door;
    logic       valid_code;
    logic [3:0] access_code;
    logic       granted;
    logic       denied;
    logic       parity_err;
    logic       busy;
    logic [2:0] state_out;

    always #5 clk = ~clk;

    card_code_tx #(.RESP_TIMEOUT(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .card_present     (card_present),
        .card_bit         (card_bit),
        .card_bit_valid   (card_bit_valid),
        .open_access_door (open_access_door),
        .valid_code       (valid_code),
        .access_code      (access_code),
        .granted          (granted),
        .denied           (denied),
        .parity_err       (parity_err),
        .busy             (busy),
        .state_out        (state_out)
    );

    // ---------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    // Vector table: code, parity bit, idle gap mid-frame, door raise cycle
    // relative to valid_code (-1 = never), door open length, expected pulse.
    typedef struct {
        logic [3:0] code;
        logic       par;
        bit         gap;
        int         door_at;
        int         door_len;
        logic [2:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    // Starts in IDLE, ends on the falling edge of the CHECK cycle.
    task automatic send_frame(input logic [3:0] code, input logic par, input bit gap);
        logic [4:0] fr;
        fr = {code, par};
        card_present   = 1'b1;
        card_bit_valid = 1'b0;
        tick();
        chk("enter_shift", state_out, 1);
        for (int b = 0; b < NBITS; b++) begin
            if (gap && b == 2) begin
                card_bit       = ~fr[4-b];   // must be ignored
                card_bit_valid = 1'b0;
                tick();
                chk("gap_in_shift", state_out, 1);
            end
            card_bit       = fr[4-b];
            card_bit_valid = 1'b1;
            tick();
        end
        card_bit_valid = 1'b0;
        card_bit       = 1'b0;
        chk("check_state", state_out, 2);
        chk("no_early_valid", valid_code, 0);
    endtask

    task automatic run_txn(input vec_t v, input bit release_card);
        int exp_k;
        send_frame(v.code, v.par, v.gap);
        tick();   // cycle after CHECK
        if (v.exp_res == R_PE) begin
            chk("perr_state", state_out, 6);
            chk("perr_pulse", {granted, denied, parity_err}, R_PE);
            chk("perr_no_valid", valid_code, 0);
            tick();
            chk("perr_one_cycle", {granted, denied, parity_err}, R_NONE);
            chk("perr_hold_remove", state_out, 6);
            chk("perr_no_valid2", valid_code, 0);
        end else begin
            chk("valid_code", valid_code, 1);
            chk("send_state", state_out, 3);
            chk("access_code", access_code, v.code);
            chk("send_no_pulse", {granted, denied, parity_err}, R_NONE);
            exp_k = (v.exp_res == R_GR) ? v.door_at + v.door_len + 1 : T;
            for (int k = 1; k <= exp_k; k++) begin
                tick();
                chk("valid_single", valid_code, 0);
                if (k < exp_k) begin
                    chk("wait_no_pulse", {granted, denied, parity_err}, R_NONE);
                    chk("wait_state", state_out,
                        (v.door_at >= 0 && k > v.door_at) ? 5 : 4);
                end else begin
                    chk("result_pulse", {granted, denied, parity_err}, v.exp_res);
                    chk("result_state", state_out, 6);
                    chk("code_held", access_code, v.code);
                end
                open_access_door = (v.door_at >= 0 && k >= v.door_at &&
                                    k < v.door_at + v.door_len);
            end
            open_access_door = 1'b0;
            tick();
            chk("result_one_cycle", {granted, denied, parity_err}, R_NONE);
            chk("remove_hold", state_out, 6);
        end
        if (release_card) begin
            card_present = 1'b0;
            tick();
            chk("back_idle", state_out, 0);
            chk("idle_busy", busy, 0);
            chk("idle_code_clear", access_code, 0);
        end
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        vec_t v;
        reset            = 1'b0;
        card_present     = 1'b0;
        card_bit         = 1'b0;
        card_bit_valid   = 1'b0;
        open_access_door = 1'b0;

        vecs[0] = '{4'h6, 1'b0, 1'b0,  2, 1, R_GR};
        vecs[1] = '{4'h2, 1'b1, 1'b0, -1, 0, R_DN};
        vecs[2] = '{4'h6, 1'b1, 1'b0, -1, 0, R_BAD};
        vecs[3] = '{4'hB, 1'b1, 1'b1,  3, 2, R_GR};   // door in last waiting cycle
        vecs[4] = '{4'h4, 1'b1, 1'b0,  4, 2, R_DN};   // door one cycle too late
        vecs[5] = '{4'hF, 1'b0, 1'b0,  2, 4, R_GR};   // out-of-range code passes
        vecs[6] = '{4'h0, 1'b0, 1'b1, -1, 0, R_DN};
        vecs[7] = '{4'h9, 1'b1, 1'b1, -1, 0, R_BAD};

        // Reset state
        tick();
        tick();
        chk("rst_state", state_out, 0);
        chk("rst_outputs", {valid_code, access_code, granted, denied, parity_err, busy}, 0);
        reset = 1'b1;
        tick();
        chk("idle_after_rst", state_out, 0);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], 1'b1);
        end

        // Abort after two bits; strobes outside SHIFT are ignored.
        card_bit       = 1'b1;
        card_bit_valid = 1'b1;
        tick();
        chk("idle_ignores_strobe", state_out, 0);
        card_bit_valid = 1'b0;
        card_present   = 1'b1;
        tick();
        chk("abort_shift", state_out, 1);
        card_bit_valid = 1'b1;
        tick();
        tick();
        chk("abort_still_shift", state_out, 1);
        card_present = 1'b0;
        tick();
        card_bit_valid = 1'b0;
        chk("abort_idle", state_out, 0);
        chk("abort_outputs", {valid_code, access_code, granted, denied, parity_err, busy}, 0);
        tick();
        chk("abort_quiet", {granted, denied, parity_err}, R_NONE);
        v = '{4'h6, 1'b0, 1'b0, 2, 2, R_GR};
        run_txn(v, 1'b1);

        // Card held after grant: no second transaction until re-presented.
        v = '{4'h5, 1'b0, 1'b0, 2, 1, R_GR};
        run_txn(v, 1'b0);
        for (int c = 0; c < 5; c++) begin
            card_bit_valid = c[0];
            card_bit       = 1'b1;
            tick();
            chk("held_no_valid", valid_code, 0);
            chk("held_remove", state_out, 6);
            chk("held_code", access_code, 4'h5);
        end
        card_bit_valid = 1'b0;
        card_present   = 1'b0;
        tick();
        chk("held_released", state_out, 0);
        run_txn(v, 1'b1);

        // Reset during WAIT_CLOSE
        send_frame(4'hA, 1'b0, 1'b0);
        tick();
        chk("rstwc_valid", valid_code, 1);
        tick();
        open_access_door = 1'b1;
        tick();
        tick();
        chk("rstwc_in_wait_close", state_out, 5);
        reset = 1'b0;
        tick();
        chk("rstwc_state", state_out, 0);
        chk("rstwc_outputs", {valid_code, access_code, granted, denied, parity_err, busy}, 0);
        reset            = 1'b1;
        open_access_door = 1'b0;
        card_present     = 1'b0;
        tick();
        chk("rstwc_idle", state_out, 0);
        chk("rstwc_quiet", {valid_code, access_code, granted, denied, parity_err, busy}, 0);

        // ------------------------------------------------------------ report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_code_tx.md
# card_code_tx

Transmitting end of the turnstile code interface. Assembles a serial card frame from the reader head, optionally checks parity, presents the 4-bit code to the turnstile controller with a single-cycle `valid_code` strobe, and then tracks the controller's `open_access_door` response to classify the transaction as granted or denied. It sits between the card reader head and the turnstile controller, one instance per gate.

## Interface

**Parameters**
- `RESP_TIMEOUT`, default 4: cycles to wait after `valid_code` for the door to open before declaring denial. Legal range is 3..15.

**Ports**
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low.
- `card_present` in 1: a card is in the reader field.
- `card_bit` in 1: serial frame data, MSB first.
- `card_bit_valid` in 1: `card_bit` is sampled in any cycle where this is 1.
- `open_access_door` in 1: door-open response from the turnstile controller.
- `valid_code` out 1: one-cycle strobe to the controller.
- `access_code` out 4: code to the controller.
- `granted` out 1: one-cycle pulse at the end of a granted transaction.
- `denied` out 1: one-cycle pulse on response timeout.
- `parity_err` out 1: one-cycle pulse on a bad frame.
- `busy` out 1: high whenever the state is not IDLE.
- `state_out` out 3: current state encoding.

## Operation

**Frame format**
- 4 code bits, MSB first, followed by 1 even-parity bit.
- Even parity means the XOR of all 5 bits is 0.

**State machine**
- IDLE (0):
  - Move to SHIFT when `card_present`=1.
  - Clear the bit counter.
- SHIFT (1):
  - Shift in `card_bit` on each `card_bit_valid`=1 cycle.
  - After the last frame bit is captured, move to CHECK.
  - If `card_present`=0 at any point, abort to IDLE with no pulses and clear the shift register.
- CHECK (2):
  - Parity good: move to SEND and latch the 4 code bits into `access_code`.
  - Parity bad: pulse `parity_err` and move to REMOVE.
- SEND (3):
  - Drive `valid_code`=1 for exactly this cycle.
  - Move to WAIT_RESP and clear the response counter.
- WAIT_RESP (4):
  - If `open_access_door`=1, move to WAIT_CLOSE.
  - Otherwise, when the counter reaches `RESP_TIMEOUT`-1, pulse `denied` and move to REMOVE.
- WAIT_CLOSE (5):
  - When `open_access_door`=0, pulse `granted` and move to REMOVE.
- REMOVE (6):
  - Wait for `card_present`=0, then move to IDLE.
  - This guarantees exactly one transaction per card tap.
- Encoding 7 is illegal and recovers to IDLE.

**Output rules**
- `access_code` holds its value from SEND until the next entry to IDLE, where it is cleared to 0.
- The code range check (4..11) belongs to the controller. This block never filters codes.
- `card_present` dropping in any state after CHECK does not abort; the transaction completes.
- `card_bit_valid` outside SHIFT is ignored.

## Timing

- Reset (`reset`=0 at a rising edge):
  - State returns to IDLE.
  - All outputs become 0; `state_out`=0.
  - The shift register, bit counter and response counter are cleared.
  - This applies from any state, including mid-transaction.
- Latency:
  - Last bit strobe at cycle N → CHECK at N+1 → `valid_code` at N+2.
  - The controller asserts `open_access_door` from N+4, which is 2 cycles after `valid_code`. For this reason `RESP_TIMEOUT` must be ≥3.
- Pulse alignment: `granted`, `denied` and `parity_err` are registered, each lasts 1 cycle, and they are mutually exclusive.
- Response counter: 4-bit, saturates at `RESP_TIMEOUT`-1, and never wraps.
- SHIFT edge case: back-to-back strobes on consecutive cycles are legal.

## Configuration

- `CARD_CODE_PARITY_EN` defined:
  - 5-bit frame with parity check, as described above.
- `CARD_CODE_PARITY_EN` undefined:
  - 4-bit frame with no parity bit.
  - CHECK always proceeds to SEND.
  - `parity_err` is tied to 0.
  - The state encodings are unchanged.

## Structure

- Package `turnstile_pkg` holds:
  - the state enum (3-bit);
  - `CODE_W`=4;
  - `FRAME_LEN` (5 or 4, selected by the macro);
  - `CODE_MIN`=4 and `CODE_MAX`=11, shared with the controller and the bench model.
- Sub-module `card_frame_shift`:
  - Shift register and bit counter.
  - Outputs `frame_done` and `frame_data`, with a synchronous clear on abort or reset.

## Test plan

- Bits 0,1,1,0 plus parity 0, against a controller model that grants → `valid_code` 2 cycles after the last strobe, `access_code`=6, door opens 2 cycles later, `granted` pulses the cycle after the door closes.
- Bits 0,0,1,0 plus parity 1 (code 2) → `valid_code`, door never opens, `denied` pulses at cycle `RESP_TIMEOUT` after SEND, state reaches REMOVE.
- Bits 0,1,1,0 plus parity 1 → `parity_err` pulse, no `valid_code`, state stays in REMOVE until `card_present`=0.
- `card_present` drops after 2 bits → back to IDLE, no pulses, `access_code`=0; the next full frame decodes correctly.
- `reset`=0 during WAIT_CLOSE → next cycle state=IDLE and all outputs 0.
- `card_present` held high after `granted` → no second `valid_code` until the card is removed and re-presented.
